// File: rtl/ahb_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_slave_pkg
//  Purpose  : Shared types, codes and helpers for the AHB-Lite slave FSM
//  Revision : 1.0 - initial release
// ============================================================================
package ahb_slave_pkg;

  // Controller states; the numeric values are visible on the state port.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_REG   = 3'd3,
    S_WAIT  = 3'd4,
    S_ERR1  = 3'd5,
    S_ERR2  = 3'd6
  } state_t;

  // AHB htrans encodings.
  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  // Register offsets relative to the end of the data window.
  localparam int REG_RX_SIZE  = 0;
  localparam int REG_STATUS   = 2;
  localparam int REG_ERROR    = 4;
  localparam int REG_TX_PSIZE = 8;

  // Register selector produced by the address decoder.
  typedef enum logic [1:0] {
    SEL_RX_SIZE  = 2'd0,
    SEL_STATUS   = 2'd1,
    SEL_ERROR    = 2'd2,
    SEL_TX_PSIZE = 2'd3
  } reg_sel_t;

  // Transfer size in bytes for an hsize code (hsize=3 yields 8, never legal).
  function automatic logic [3:0] sizeBytes(input logic [1:0] sz);
    return 4'd1 << sz;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_addr_decode.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_addr_decode
//  Purpose  : Combinational decode of an AHB address phase against the data
//             window and the register map
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_addr_decode
  import ahb_slave_pkg::*;
#(
  parameter int ADDR_W    = 7,
  parameter int BUF_BYTES = 64
) (
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        hsize,
  input  logic              hwrite,
  output logic              isData,
  output logic              isReg,
  output logic              legal,
  output reg_sel_t          regSel
);

  logic              w_aligned;
  logic [ADDR_W-1:0] w_off;

  assign w_off = haddr - ADDR_W'(BUF_BYTES);

  // Natural alignment check; hsize=3 is never aligned so it is always illegal.
  always_comb begin
    w_aligned = 1'b0;
    case (hsize)
      2'd0:    w_aligned = 1'b1;
      2'd1:    w_aligned = (haddr[0] == 1'b0);
      2'd2:    w_aligned = (haddr[1:0] == 2'b00);
      default: w_aligned = 1'b0;
    endcase
  end

  // Window / register match and per-register access rules.
  always_comb begin
    isData = (haddr < ADDR_W'(BUF_BYTES));
    isReg  = 1'b0;
    legal  = 1'b0;
    regSel = SEL_RX_SIZE;
    if (isData) begin
      legal = w_aligned;
    end else if (w_off == ADDR_W'(REG_RX_SIZE)) begin
      isReg  = 1'b1;
      regSel = SEL_RX_SIZE;
      legal  = !hwrite && (hsize <= 2'd1);
    end else if (w_off == ADDR_W'(REG_STATUS)) begin
      isReg  = 1'b1;
      regSel = SEL_STATUS;
      legal  = !hwrite && (hsize <= 2'd1);
    end else if (w_off == ADDR_W'(REG_ERROR)) begin
      isReg  = 1'b1;
      regSel = SEL_ERROR;
      legal  = !hwrite && (hsize == 2'd0);
    end else if (w_off == ADDR_W'(REG_TX_PSIZE)) begin
      isReg  = 1'b1;
      regSel = SEL_TX_PSIZE;
      legal  = (hsize == 2'd0);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ahb_slave_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_slave_fsm
//  Purpose  : AHB-Lite slave control FSM for the USB endpoint data path:
//             address-phase capture, buffer wait states, two-cycle ERROR
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_slave_fsm
  import ahb_slave_pkg::*;
#(
  parameter int ADDR_W    = 7,
  parameter int BUF_BYTES = 64,
  parameter int CNT_W     = $clog2(BUF_BYTES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic [1:0]        hsize,
  input  logic              hwrite,
  input  logic [CNT_W-1:0]  bufFree,
  input  logic [CNT_W-1:0]  bufUsed,
  output logic              hready,
  output logic              hresp,
  output logic [2:0]        state,
  output logic [ADDR_W-1:0] dataAddr,
  output logic [1:0]        dataSize,
  output logic              storeTxData,
  output logic              getRxData,
  output logic              regRead,
  output logic              txPacketSizeChanged
);

  state_t            r_state;
  logic              r_hready;
  logic              r_hresp;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_write;
  logic              r_store;
  logic              r_get;
  logic              r_regrd;
  logic              r_txpsc;

  logic              w_isData;
  logic              w_isReg;
  logic              w_legal;
  reg_sel_t          w_regSel;
  logic              w_accept;
  logic              w_room_now;
  logic              w_room_wait;

  ahb_addr_decode #(
    .ADDR_W    (ADDR_W),
    .BUF_BYTES (BUF_BYTES)
  ) u_decode (
    .haddr  (haddr),
    .hsize  (hsize),
    .hwrite (hwrite),
    .isData (w_isData),
    .isReg  (w_isReg),
    .legal  (w_legal),
    .regSel (w_regSel)
  );

  // Address phase counts only while we are ready; hready=0 masks the bus.
  assign w_accept = r_hready && hsel &&
                    ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

  // Buffer occupancy check for a fresh address phase.
  assign w_room_now = hwrite ? (bufFree >= CNT_W'(sizeBytes(hsize)))
                             : (bufUsed >= CNT_W'(sizeBytes(hsize)));

  // Same check for the transfer parked in WAIT, using the captured phase.
  assign w_room_wait = r_write ? (bufFree >= CNT_W'(sizeBytes(r_size)))
                               : (bufUsed >= CNT_W'(sizeBytes(r_size)));

  // Single state machine; all outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_hready <= 1'b1;
      r_hresp  <= 1'b0;
      r_addr   <= '0;
      r_size   <= '0;
      r_write  <= 1'b0;
      r_store  <= 1'b0;
      r_get    <= 1'b0;
      r_regrd  <= 1'b0;
      r_txpsc  <= 1'b0;
    end else begin
      r_store <= 1'b0;
      r_get   <= 1'b0;
      r_regrd <= 1'b0;
      r_txpsc <= 1'b0;
      case (r_state)
        S_WAIT: begin
          if (w_room_wait) begin
            r_state  <= r_write ? S_WRITE : S_READ;
            r_hready <= 1'b1;
            r_store  <= r_write;
            r_get    <= !r_write;
          end
        end
        S_ERR1: begin
          r_state  <= S_ERR2;
          r_hready <= 1'b1;
          r_hresp  <= 1'b1;
        end
        default: begin
          if (w_accept) begin
            r_addr  <= haddr;
            r_size  <= hsize;
            r_write <= hwrite;
            if (!w_legal) begin
              r_state  <= S_ERR1;
              r_hready <= 1'b0;
              r_hresp  <= 1'b1;
            end else if (w_isData) begin
              r_hresp <= 1'b0;
              if (w_room_now) begin
                r_state  <= hwrite ? S_WRITE : S_READ;
                r_hready <= 1'b1;
                r_store  <= hwrite;
                r_get    <= !hwrite;
              end else begin
                r_state  <= S_WAIT;
                r_hready <= 1'b0;
              end
            end else begin
              r_state  <= S_REG;
              r_hready <= 1'b1;
              r_hresp  <= 1'b0;
              r_regrd  <= w_isReg && !hwrite;
              r_txpsc  <= w_isReg && hwrite && (w_regSel == SEL_TX_PSIZE);
            end
          end else begin
            r_state  <= S_IDLE;
            r_hready <= 1'b1;
            r_hresp  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign hready              = r_hready;
  assign hresp               = r_hresp;
  assign state               = r_state;
  assign dataAddr            = r_addr;
  assign dataSize            = r_size;
  assign storeTxData         = r_store;
  assign getRxData           = r_get;
  assign regRead             = r_regrd;
  assign txPacketSizeChanged = r_txpsc;

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_slave_fsm
//  Purpose  : Directed, table-driven bench for ahb_slave_fsm (64-byte and
//             128-byte window builds)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_slave_fsm;

  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NS = 2'd2, T_SEQ = 2'd3;
  localparam logic [2:0] E_IDLE = 3'd0, E_WRITE = 3'd1, E_READ = 3'd2, E_REG = 3'd3,
                         E_WAIT = 3'd4, E_ERR1 = 3'd5, E_ERR2 = 3'd6;

  logic       clk = 1'b0;
  logic       rst;
  logic       hsel, hwrite;
  logic [6:0] haddr;
  logic [1:0] htrans, hsize;
  logic [6:0] bufFree, bufUsed;
  logic       hready, hresp, storeTxData, getRxData, regRead, txPsc;
  logic [2:0] state;
  logic [6:0] dataAddr;
  logic [1:0] dataSize;

  logic       b_hsel, b_hwrite;
  logic [7:0] b_haddr;
  logic [1:0] b_htrans, b_hsize;
  logic [7:0] b_free, b_used;
  logic       b_hready, b_hresp, b_store, b_get, b_regrd, b_txpsc;
  logic [2:0] b_state;
  logic [7:0] b_daddr;
  logic [1:0] b_dsize;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ahb_slave_fsm u_dut (
    .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hsize(hsize), .hwrite(hwrite), .bufFree(bufFree), .bufUsed(bufUsed),
    .hready(hready), .hresp(hresp), .state(state), .dataAddr(dataAddr),
    .dataSize(dataSize), .storeTxData(storeTxData), .getRxData(getRxData),
    .regRead(regRead), .txPacketSizeChanged(txPsc)
  );

  ahb_slave_fsm #(.ADDR_W(8), .BUF_BYTES(128)) u_dut2 (
    .clk(clk), .rst(rst), .hsel(b_hsel), .haddr(b_haddr), .htrans(b_htrans),
    .hsize(b_hsize), .hwrite(b_hwrite), .bufFree(b_free), .bufUsed(b_used),
    .hready(b_hready), .hresp(b_hresp), .state(b_state), .dataAddr(b_daddr),
    .dataSize(b_dsize), .storeTxData(b_store), .getRxData(b_get),
    .regRead(b_regrd), .txPacketSizeChanged(b_txpsc)
  );

  typedef struct {
    logic       sel;
    logic [1:0] trans;
    logic [6:0] addr;
    logic [1:0] size;
    logic       wr;
    logic [6:0] free;
    logic [6:0] used;
    logic [2:0] e_state;
    logic       e_hready;
    logic       e_hresp;
    logic [3:0] e_strb;   // {store, get, regRead, txPsc}
    logic [6:0] e_daddr;
    logic [1:0] e_dsize;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t mk(logic sel, logic [1:0] trans, logic [6:0] addr,
                              logic [1:0] size, logic wr, logic [6:0] free,
                              logic [6:0] used, logic [2:0] st, logic hr,
                              logic rs, logic [3:0] strb, logic [6:0] da,
                              logic [1:0] ds);
    vec_t v;
    v.sel = sel; v.trans = trans; v.addr = addr; v.size = size; v.wr = wr;
    v.free = free; v.used = used; v.e_state = st; v.e_hready = hr;
    v.e_hresp = rs; v.e_strb = strb; v.e_daddr = da; v.e_dsize = ds;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sel, input logic [1:0] trans, input logic [6:0] addr,
                       input logic [1:0] size, input logic wr);
    hsel = sel; htrans = trans; haddr = addr; hsize = size; hwrite = wr;
  endtask

  task automatic chk(input string name, input logic [2:0] st, input logic hr,
                     input logic rs, input logic [3:0] strb);
    check({name, ".state"},  32'(state),  32'(st));
    check({name, ".hready"}, 32'(hready), 32'(hr));
    check({name, ".hresp"},  32'(hresp),  32'(rs));
    check({name, ".strobes"}, 32'({storeTxData, getRxData, regRead, txPsc}), 32'(strb));
  endtask

  task automatic chk2(input string name, input logic [2:0] st, input logic hr,
                      input logic rs, input logic [3:0] strb);
    check({name, ".state"},  32'(b_state),  32'(st));
    check({name, ".hready"}, 32'(b_hready), 32'(hr));
    check({name, ".hresp"},  32'(b_hresp),  32'(rs));
    check({name, ".strobes"}, 32'({b_store, b_get, b_regrd, b_txpsc}), 32'(strb));
  endtask

  initial begin
    vecs[0]  = mk(1, T_NS,   7'h04, 2, 1, 8, 8, E_WRITE, 1, 0, 4'b1000, 7'h04, 2);
    vecs[1]  = mk(1, T_IDLE, 7'h00, 0, 0, 8, 8, E_IDLE,  1, 0, 4'b0000, 7'h04, 2);
    vecs[2]  = mk(1, T_NS,   7'h40, 0, 0, 8, 8, E_REG,   1, 0, 4'b0010, 7'h40, 0);
    vecs[3]  = mk(1, T_NS,   7'h44, 1, 0, 8, 8, E_ERR1,  0, 1, 4'b0000, 7'h44, 1);
    vecs[4]  = mk(1, T_NS,   7'h00, 0, 1, 8, 8, E_ERR2,  1, 1, 4'b0000, 7'h44, 1);
    vecs[5]  = mk(1, T_NS,   7'h48, 0, 1, 8, 8, E_REG,   1, 0, 4'b0001, 7'h48, 0);
    vecs[6]  = mk(1, T_NS,   7'h48, 1, 1, 8, 8, E_ERR1,  0, 1, 4'b0000, 7'h48, 1);
    vecs[7]  = mk(1, T_IDLE, 7'h00, 0, 0, 8, 8, E_ERR2,  1, 1, 4'b0000, 7'h48, 1);
    vecs[8]  = mk(1, T_IDLE, 7'h00, 0, 0, 8, 8, E_IDLE,  1, 0, 4'b0000, 7'h48, 1);
    vecs[9]  = mk(1, T_NS,   7'h41, 2, 0, 8, 8, E_ERR1,  0, 1, 4'b0000, 7'h41, 2);
    vecs[10] = mk(1, T_SEQ,  7'h00, 3, 0, 8, 8, E_ERR2,  1, 1, 4'b0000, 7'h41, 2);
    vecs[11] = mk(1, T_NS,   7'h00, 3, 0, 8, 8, E_ERR1,  0, 1, 4'b0000, 7'h00, 3);
    vecs[12] = mk(1, T_IDLE, 7'h00, 0, 0, 8, 8, E_ERR2,  1, 1, 4'b0000, 7'h00, 3);
    vecs[13] = mk(1, T_NS,   7'h42, 1, 1, 8, 8, E_ERR1,  0, 1, 4'b0000, 7'h42, 1);
    vecs[14] = mk(1, T_IDLE, 7'h00, 0, 0, 8, 8, E_ERR2,  1, 1, 4'b0000, 7'h42, 1);
    vecs[15] = mk(1, T_NS,   7'h11, 1, 0, 8, 4, E_ERR1,  0, 1, 4'b0000, 7'h11, 1);
    vecs[16] = mk(1, T_IDLE, 7'h00, 0, 0, 8, 8, E_ERR2,  1, 1, 4'b0000, 7'h11, 1);
    vecs[17] = mk(1, T_NS,   7'h4C, 0, 0, 8, 8, E_ERR1,  0, 1, 4'b0000, 7'h4C, 0);
    vecs[18] = mk(1, T_IDLE, 7'h00, 0, 0, 8, 8, E_ERR2,  1, 1, 4'b0000, 7'h4C, 0);
    vecs[19] = mk(1, T_IDLE, 7'h00, 0, 0, 8, 8, E_IDLE,  1, 0, 4'b0000, 7'h4C, 0);
    vecs[20] = mk(1, T_NS,   7'h42, 1, 0, 8, 8, E_REG,   1, 0, 4'b0010, 7'h42, 1);
    vecs[21] = mk(1, T_NS,   7'h48, 0, 0, 8, 8, E_REG,   1, 0, 4'b0010, 7'h48, 0);
    vecs[22] = mk(1, T_NS,   7'h08, 2, 1, 3, 8, E_WAIT,  0, 0, 4'b0000, 7'h08, 2);
    vecs[23] = mk(1, T_NS,   7'h30, 0, 0, 4, 8, E_WRITE, 1, 0, 4'b1000, 7'h08, 2);
    vecs[24] = mk(1, T_IDLE, 7'h00, 0, 0, 8, 8, E_IDLE,  1, 0, 4'b0000, 7'h08, 2);
    vecs[25] = mk(0, T_NS,   7'h00, 0, 1, 8, 8, E_IDLE,  1, 0, 4'b0000, 7'h08, 2);
    vecs[26] = mk(1, T_NS,   7'h3C, 2, 0, 8, 4, E_READ,  1, 0, 4'b0100, 7'h3C, 2);
    vecs[27] = mk(1, T_IDLE, 7'h00, 0, 0, 8, 8, E_IDLE,  1, 0, 4'b0000, 7'h3C, 2);

    rst = 1'b1;
    drive(0, T_IDLE, 7'h00, 0, 0);
    bufFree = 7'd8; bufUsed = 7'd8;
    b_hsel = 0; b_htrans = T_IDLE; b_haddr = 8'h00; b_hsize = 0; b_hwrite = 0;
    b_free = 8'd8; b_used = 8'd8;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("reset", E_IDLE, 1, 0, 4'b0000);
    check("reset.dataAddr", 32'(dataAddr), 32'h0);
    check("reset.dataSize", 32'(dataSize), 32'h0);
    chk2("reset2", E_IDLE, 1, 0, 4'b0000);

    // Table-driven single-cycle sequence
    for (int i = 0; i < 28; i++) begin
      drive(vecs[i].sel, vecs[i].trans, vecs[i].addr, vecs[i].size, vecs[i].wr);
      bufFree = vecs[i].free; bufUsed = vecs[i].used;
      tick();
      chk($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_hready,
          vecs[i].e_hresp, vecs[i].e_strb);
      check($sformatf("vec%0d.dataAddr", i), 32'(dataAddr), 32'(vecs[i].e_daddr));
      check($sformatf("vec%0d.dataSize", i), 32'(dataSize), 32'(vecs[i].e_dsize));
    end

    // Half-word read waits three cycles for RX data, then completes
    bufFree = 7'd8; bufUsed = 7'd1;
    drive(1, T_NS, 7'h10, 1, 0);
    tick(); chk("rdwait.w1", E_WAIT, 0, 0, 4'b0000);
    drive(1, T_NS, 7'h20, 0, 1);
    tick(); chk("rdwait.w2", E_WAIT, 0, 0, 4'b0000);
    tick(); chk("rdwait.w3", E_WAIT, 0, 0, 4'b0000);
    bufUsed = 7'd2;
    drive(1, T_IDLE, 7'h00, 0, 0);
    tick(); chk("rdwait.done", E_READ, 1, 0, 4'b0100);
    check("rdwait.dataAddr", 32'(dataAddr), 32'h10);
    tick(); chk("rdwait.idle", E_IDLE, 1, 0, 4'b0000);

    // Back-to-back byte writes, then BUSY, then one more SEQ beat
    bufFree = 7'd8;
    drive(1, T_NS, 7'h00, 0, 1);  tick(); chk("b2b.0", E_WRITE, 1, 0, 4'b1000);
    drive(1, T_SEQ, 7'h01, 0, 1); tick(); chk("b2b.1", E_WRITE, 1, 0, 4'b1000);
    check("b2b.1.dataAddr", 32'(dataAddr), 32'h01);
    drive(1, T_SEQ, 7'h02, 0, 1); tick(); chk("b2b.2", E_WRITE, 1, 0, 4'b1000);
    check("b2b.2.dataAddr", 32'(dataAddr), 32'h02);
    drive(1, T_BUSY, 7'h03, 0, 1); tick(); chk("b2b.busy", E_IDLE, 1, 0, 4'b0000);
    drive(1, T_SEQ, 7'h03, 0, 1); tick(); chk("b2b.3", E_WRITE, 1, 0, 4'b1000);
    drive(1, T_IDLE, 7'h00, 0, 0); tick(); chk("b2b.end", E_IDLE, 1, 0, 4'b0000);

    // Reset taken while stalled in WAIT
    bufFree = 7'd0;
    drive(1, T_NS, 7'h00, 2, 1); tick(); chk("rstwait.wait", E_WAIT, 0, 0, 4'b0000);
    drive(1, T_IDLE, 7'h00, 0, 0);
    bufFree = 7'd8;
    rst = 1'b1; tick(); chk("rstwait.idle", E_IDLE, 1, 0, 4'b0000);
    rst = 1'b0;

    // Reset taken in ERR1
    drive(1, T_NS, 7'h01, 1, 0); tick(); chk("rsterr.err1", E_ERR1, 0, 1, 4'b0000);
    drive(1, T_IDLE, 7'h00, 0, 0);
    rst = 1'b1; tick(); chk("rsterr.idle", E_IDLE, 1, 0, 4'b0000);
    rst = 1'b0;

    // 128-byte window build: registers decode at 0x80 upwards
    b_hsel = 1; b_htrans = T_NS; b_haddr = 8'h80; b_hsize = 0; b_hwrite = 0;
    tick(); chk2("w128.rxsize", E_REG, 1, 0, 4'b0010);
    check("w128.dataAddr", 32'(b_daddr), 32'h80);
    b_haddr = 8'h88; b_hwrite = 1;
    tick(); chk2("w128.txpsize", E_REG, 1, 0, 4'b0001);
    b_haddr = 8'h40; b_hsize = 2; b_hwrite = 1; b_free = 8'd4;
    tick(); chk2("w128.datawr", E_WRITE, 1, 0, 4'b1000);
    b_haddr = 8'h7F; b_hsize = 0; b_hwrite = 0; b_used = 8'd1;
    tick(); chk2("w128.datard", E_READ, 1, 0, 4'b0100);
    b_haddr = 8'h84; b_hsize = 1;
    tick(); chk2("w128.errhalf", E_ERR1, 0, 1, 4'b0000);
    b_htrans = T_IDLE;
    tick(); chk2("w128.err2", E_ERR2, 1, 1, 4'b0000);
    tick(); chk2("w128.idle", E_IDLE, 1, 0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
